// File: rtl/adder_accum_amisha.sv
// Accumulates 5-bit {cout, sum} beats from the 4-bit carry adder into a wide
// running total; pulses done after NUM_OPS_AMISHA accepted beats.
module adder_accum_amisha #(
   parameter int NUM_OPS_AMISHA = 4,
   parameter int ACC_W_AMISHA   = 8
) (
   input  logic                    clk_amisha,
   input  logic                    reset_amisha,
   input  logic                    start_amisha,
   input  logic                    in_valid_amisha,
   input  logic [3:0]              sum_amisha,
   input  logic                    cout_amisha,
   output logic                    in_ready_amisha,
   output logic [ACC_W_AMISHA-1:0] acc_amisha,
   output logic                    ovf_amisha,
   output logic [3:0]              count_amisha,
   output logic                    busy_amisha,
   output logic                    done_amisha
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [3:0] LAST_CNT = 4'(NUM_OPS_AMISHA - 1);

   logic [1:0]              state_q, state_d;
   logic [ACC_W_AMISHA-1:0] acc_q, acc_d;
   logic                    ovf_q, ovf_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [ACC_W_AMISHA:0]   sum_w;

   // One extra bit catches the carry out of the accumulator MSB.
   assign sum_w = {1'b0, acc_q}
                + {{(ACC_W_AMISHA-4){1'b0}}, cout_amisha, sum_amisha};

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_amisha) begin
               state_d = S_ACCUM;
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         S_ACCUM: begin
            if (in_valid_amisha) begin
               acc_d = sum_w[ACC_W_AMISHA-1:0];
               ovf_d = ovf_q | sum_w[ACC_W_AMISHA];
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == LAST_CNT)
                  state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready_amisha = (state_q == S_ACCUM);
   assign busy_amisha     = (state_q == S_ACCUM);
   assign done_amisha     = (state_q == S_DONE);
   assign acc_amisha      = acc_q;
   assign ovf_amisha      = ovf_q;
   assign count_amisha    = cnt_q;

endmodule

// File: doc/adder_accum_amisha.md
# adder_accum_amisha

Sequential accumulator downstream of the 4-bit carry adder. Each accepted beat takes the adder's 5-bit result {cout, sum}, adds it into a wide running total, and counts beats. After a programmed number of beats it reports a one-cycle completion pulse and holds the total and a sticky overflow flag until the next run.

## Interface
Parameters:
- NUM_OPS_AMISHA, default 4: beats per run; legal 1..15.
- ACC_W_AMISHA, default 8: accumulator width; legal ≥ 5.

Ports:
- clk_amisha, input, 1: single clock; all state changes on the rising edge.
- reset_amisha, input, 1: reset, asynchronous, active-high.
- start_amisha, input, 1: begins a run; honoured only in IDLE.
- in_valid_amisha, input, 1: sum/cout inputs carry a valid beat.
- sum_amisha, input, 4: adder sum bits.
- cout_amisha, input, 1: adder carry-out.
- in_ready_amisha, output, 1: block accepts a beat this cycle.
- acc_amisha, output, ACC_W_AMISHA: running or final total.
- ovf_amisha, output, 1: sticky flag; the total wrapped during the current or last run.
- count_amisha, output, 4: beats accepted in the current or last run.
- busy_amisha, output, 1: high in ACCUM.
- done_amisha, output, 1: one-cycle pulse when a run completes.

## Operation
- Beat value r = {cout_amisha, sum_amisha}, zero-extended to ACC_W_AMISHA. Range is 0..30.
- A beat is accepted on an edge where in_valid_amisha and in_ready_amisha are both high.
- FSM has three states: IDLE, ACCUM and DONE.
  - IDLE -> ACCUM on start_amisha. On that same edge, acc, ovf and count are cleared to 0.
  - In ACCUM, each accepted beat does the following:
    - acc <= (acc + r) mod 2^ACC_W_AMISHA.
    - ovf is set if that addition carries out of the MSB. Once set, ovf stays set until the next start.
    - count is incremented.
  - ACCUM -> DONE on the edge that accepts beat number NUM_OPS_AMISHA, using the count value before the increment.
  - DONE -> IDLE unconditionally on the next edge.
- Outputs by state:
  - in_ready_amisha = (state == ACCUM).
  - busy_amisha = (state == ACCUM).
  - done_amisha = (state == DONE).
  - All are decoded from the registered state, so there are no combinational paths from inputs to outputs.
- Inputs that are ignored:
  - start_amisha is ignored in ACCUM and DONE.
  - in_valid_amisha is ignored outside ACCUM, and acc is unchanged.
  - Beats with in_valid_amisha low are not counted, so gaps are allowed.
- acc, ovf and count hold their final values through DONE and IDLE until the next start.

## Timing
- Reset, asynchronous and immediate:
  - State goes to IDLE.
  - acc_amisha=0, ovf_amisha=0, count_amisha=0.
  - in_ready_amisha=0, busy_amisha=0, done_amisha=0.
  - A reset mid-run abandons the run; no done pulse is produced.
- Start latency: start sampled at edge k gives in_ready_amisha=1 from cycle k+1.
- Beat latency: a beat accepted at edge k is reflected in acc_amisha and count_amisha from cycle k+1.
- Completion:
  - If the last beat is accepted at edge k, done_amisha is high for cycle k+1 only and in_ready_amisha is low in that cycle.
  - In IDLE from k+2, a start is honoured.
  - Minimum run length is NUM_OPS_AMISHA+2 cycles, from start to IDLE.
- Back-to-back beats: the block accepts one beat per cycle with no bubbles.
- Start asserted in the DONE cycle is ignored. It must be held or re-asserted in IDLE.
- Wrap-around: acc wraps modulo 2^ACC_W_AMISHA and never saturates. ovf records any wrap.

## Test plan
1. Basic run (NUM_OPS=4, ACC_W=8):
   - Stimulus: start, then back-to-back beats {0,15}, {1,0}, {1,4}, {0,14}. These correspond to the adder cases 0+15, 4+12, 13+7 and 5+9.
   - Required response: acc steps 15, 31, 51, 65; final acc=0x41, count=4, ovf=0; done high exactly one cycle, one cycle after the fourth beat.
2. Gapped input:
   - Stimulus: the same four beats with in_valid low for 3 cycles between each beat.
   - Required response: same final acc=65; busy stays high throughout; done occurs only after the fourth valid beat.
3. Overflow (NUM_OPS=15):
   - Stimulus: 15 beats of {1,14}, i.e. 15+15=30.
   - Required response: final acc = 450 mod 256 = 194 (0xC2); ovf=1; ovf stays 1 through IDLE; the next start clears acc and ovf to 0.
4. Ignored inputs:
   - Stimulus: in_valid pulses in IDLE; start asserted mid-ACCUM and during the DONE cycle.
   - Required response: acc and count are unchanged by the IDLE beats; the run is not restarted; state returns to IDLE after DONE.
5. Reset mid-run:
   - Stimulus: assert reset_amisha asynchronously, between edges, after 2 accepted beats.
   - Required response: all outputs are 0 immediately; no done pulse; a following start and 4 beats produces a clean, correct total.
